// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a slow divided signal in system-clock cycles.
// Define CLK_RATIO_SYNC_EN to pass div_in through a two-flop synchronizer first.
module clk_ratio_meter #(
  parameter int CNT_W = 8
) (
  input  logic             I,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             div_s;
  logic             div_q;
  logic             rise;
  logic             do_start;
  logic             do_meas;
  logic             do_ovf;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] prev_period;

`ifdef CLK_RATIO_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge I) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= div_in;
      sync2 <= sync1;
    end
  end

  assign div_s = sync2;
`else
  assign div_s = div_in;
`endif

  assign rise = div_s & ~div_q;

  always_ff @(posedge I) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counting stops at CNT_MAX and parks in WAIT until a fresh rise restarts it.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_meas   = 1'b0;
    do_ovf    = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (rise) begin
          do_start  = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          do_meas = 1'b1;
        end else if (cnt == CNT_MAX) begin
          do_ovf    = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I) begin
    if (rst) begin
      div_q       <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      prev_period <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      div_q <= div_s;
      valid <= 1'b0;
      if (do_start) begin
        cnt  <= CNT_ONE;
        hcnt <= CNT_ONE;
      end else if (do_meas) begin
        period      <= cnt;
        high_time   <= hcnt;
        valid       <= 1'b1;
        ovf         <= 1'b0;
        locked      <= (cnt == prev_period);
        prev_period <= cnt;
        cnt         <= CNT_ONE;
        hcnt        <= CNT_ONE;
      end else if (do_ovf) begin
        ovf    <= 1'b1;
        locked <= 1'b0;
      end else if (state == MEASURE) begin
        // hcnt never exceeds cnt, so it cannot wrap before cnt saturates.
        cnt  <= cnt + CNT_ONE;
        hcnt <= hcnt + {{(CNT_W-1){1'b0}}, div_s};
      end
    end
  end

endmodule
